// File: rtl/keypad_pkg.sv
// Shared key codes, scanner state encoding and the 4x4 keypad legend.
package keypad_pkg;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        REL_DB
    } scan_state_t;

    // Maps row*4+col of a standard phone-style 4x4 pad to its key code.
    function automatic logic [3:0] decode_4x4(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = KEY_A;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = KEY_B;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = KEY_C;
            4'd12:   code = KEY_STAR;
            4'd13:   code = 4'h0;
            4'd14:   code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Application-side view of the scanner: key events and the digit entry.
interface keypad_scanner_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DIGITS = 4
);
    localparam int KW = $clog2(ROWS * COLS);
    localparam int CW = $clog2(DIGITS + 1);

    logic                  key_valid;
    logic [KW-1:0]         key_index;
    logic [3:0]            key_code;
    logic [4*DIGITS-1:0]   digits;
    logic [CW-1:0]         digit_count;
    logic                  entry_valid;
    logic [4*DIGITS-1:0]   entry_value;

    modport master (
        output key_valid, key_index, key_code,
        output digits, digit_count, entry_valid, entry_value
    );

    modport slave (
        input key_valid, key_index, key_code,
        input digits, digit_count, entry_valid, entry_value
    );
endinterface

// File: rtl/keypad_digit_buffer.sv
// BCD entry buffer: shifts in digits, '*' clears, '#' commits and clears.
module keypad_digit_buffer #(
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    output logic [4*DIGITS-1:0]           digits,
    output logic [$clog2(DIGITS+1)-1:0]   digit_count,
    output logic                          entry_valid,
    output logic [4*DIGITS-1:0]           entry_value
);
    import keypad_pkg::*;

    localparam int DW = 4 * DIGITS;

    // Apply one key event to the buffer; entry_valid is a single-cycle pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits      <= '0;
            digit_count <= '0;
            entry_valid <= 1'b0;
            entry_value <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // pre-edge values, independent of statement order.
            entry_valid <= 1'b0;
            if (key_valid) begin
                if (key_code == KEY_STAR) begin
                    digits      <= '0;
                    digit_count <= '0;
                end else if (key_code == KEY_HASH) begin
                    entry_value <= digits;
                    entry_valid <= 1'b1;
                    digits      <= '0;
                    digit_count <= '0;
                end else if (key_code <= 4'h9 && int'(digit_count) < DIGITS) begin
                    digits      <= (digits << 4) | DW'(key_code);
                    digit_count <= digit_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, row synchroniser, debounce FSM,
// key decode and the digit entry buffer.
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 8,
    parameter int DIGITS   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROWS-1:0]  row_in,
    output logic [COLS-1:0]  col_out,
    keypad_scanner_if.master bus
);
    import keypad_pkg::*;

    localparam int KW   = $clog2(ROWS * COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int CLW  = $clog2(COLS);
    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int DBW  = $clog2(DEBOUNCE + 1);

    logic [ROWS-1:0] row_meta, row_sync;
    logic [DIVW-1:0] div_cnt;
    logic            tick;

    scan_state_t     state;
    logic [CLW-1:0]  col_idx;
    logic [RW-1:0]   row_lat;
    logic [DBW-1:0]  deb_cnt;
    logic            key_valid;
    logic [KW-1:0]   key_index;
    logic [3:0]      key_code;

    logic            any_low;
    logic [RW-1:0]   low_row;
    logic            lat_high;
    logic            deb_done;
    logic [CLW-1:0]  next_col;
    logic            fire;
    logic [3:0]      rel_idx4;
    logic [KW-1:0]   rel_index;
    logic [3:0]      rel_code;

    function automatic logic [COLS-1:0] col_drive(input logic [CLW-1:0] idx);
        return ~({{(COLS-1){1'b0}}, 1'b1} << idx);
    endfunction

    // Two-flop synchroniser for the asynchronous row pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: rows idle high (pulled up), so the synchroniser resets to
            // ones to avoid a phantom press straight out of reset.
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // Sample-tick divider, wrapping every SCAN_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    assign tick = (div_cnt == DIVW'(SCAN_DIV - 1));

    // Row priority, debounce completion and release-event decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        any_low = 1'b0;
        low_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row_sync[r]) begin
                any_low = 1'b1;
                low_row = RW'(r);
            end
        end
        lat_high  = row_sync[row_lat];
        deb_done  = (int'(deb_cnt) + 1 >= DEBOUNCE);
        next_col  = (int'(col_idx) == COLS - 1) ? '0 : col_idx + 1'b1;
        fire      = tick && (state == REL_DB) && lat_high && deb_done;
        rel_idx4  = 4'(int'(row_lat) * COLS + int'(col_idx));
        rel_index = KW'(int'(row_lat) * COLS + int'(col_idx));
        rel_code  = (ROWS == 4 && COLS == 4) ? decode_4x4(rel_idx4) : rel_idx4;
    end

    // Scan/debounce FSM with registered column drive and key event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            col_idx   <= '0;
            col_out   <= col_drive('0);
            row_lat   <= '0;
            deb_cnt   <= '0;
            key_valid <= 1'b0;
            key_index <= '0;
            key_code  <= '0;
        end else begin
            key_valid <= fire;
            if (fire) begin
                key_index <= rel_index;
                key_code  <= rel_code;
            end
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (any_low) begin
                            row_lat <= low_row;
                            deb_cnt <= DBW'(1);
                            state   <= PRESS_DB;
                        end else begin
                            col_idx <= next_col;
                            col_out <= col_drive(next_col);
                        end
                    end
                    PRESS_DB: begin
                        if (lat_high) begin
                            state   <= SCAN;
                            col_idx <= next_col;
                            col_out <= col_drive(next_col);
                        end else if (deb_done) begin
                            deb_cnt <= '0;
                            state   <= HELD;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (lat_high) begin
                            deb_cnt <= DBW'(1);
                            state   <= REL_DB;
                        end
                    end
                    REL_DB: begin
                        if (!lat_high) begin
                            deb_cnt <= '0;
                            state   <= HELD;
                        end else if (deb_done) begin
                            deb_cnt <= '0;
                            state   <= SCAN;
                            col_idx <= next_col;
                            col_out <= col_drive(next_col);
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    keypad_digit_buffer #(.DIGITS(DIGITS)) u_buffer (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (fire),
        .key_code    (rel_code),
        .digits      (bus.digits),
        .digit_count (bus.digit_count),
        .entry_valid (bus.entry_valid),
        .entry_value (bus.entry_value)
    );

    assign bus.key_valid = key_valid;
    assign bus.key_index = key_index;
    assign bus.key_code  = key_code;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner with synchronised inputs, per-key press/release debounce, key-code decode and an N-digit entry buffer with clear/commit keys. It sits between the board keypad pins and the application logic, replacing ad-hoc column toggling with one registered FSM. It delivers one clean event per physical key release and a committed multi-digit number.

## Interface
- ROWS, 4, keypad rows (≥2)
- COLS, 4, keypad columns (≥2)
- SCAN_DIV, 1000, clk cycles each column is driven before its rows are sampled (≥4)
- DEBOUNCE, 8, consecutive identical samples needed to accept a press or release (≥1)
- DIGITS, 4, entry-buffer depth in BCD digits (≥1)
- KW = $clog2(ROWS*COLS), derived key-index width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- row_in  in  ROWS  keypad rows, active-low, pulled up externally; asynchronous
- col_out  out  COLS  column drive, active-low, exactly one bit low at all times
- key_valid  out  1  one-cycle pulse on accepted key release
- key_index  out  KW  row*COLS+col of the released key, valid with key_valid
- key_code  out  4  decoded code, valid with key_valid
- digits  out  4*DIGITS  entry buffer; digits[3:0] is the newest digit
- digit_count  out  $clog2(DIGITS+1)  digits currently held
- entry_valid  out  1  one-cycle pulse on commit
- entry_value  out  4*DIGITS  committed buffer, held until the next commit

## Operation
- row_in passes through a 2-flop synchroniser. All decisions use the synchronised value.
- Sample tick: a divider counter wraps every SCAN_DIV cycles. All FSM decisions occur only on ticks.
- FSM states:
  - SCAN: on each tick with no row low, advance to the next column, wrapping COLS-1→0.
  - SCAN, row low: on a tick with any row low, latch the lowest-index low row plus the current column. Go to PRESS_DB with deb_cnt=1.
  - PRESS_DB: column is frozen. A tick with the latched row still low increments deb_cnt; at deb_cnt==DEBOUNCE go to HELD. A tick with the latched row high goes back to SCAN and advances the column.
  - HELD: a tick with the latched row high goes to REL_DB with deb_cnt=1. Other rows are ignored, so there is no rollover.
  - REL_DB: a tick with the row high increments deb_cnt. At DEBOUNCE, pulse key_valid, update the buffer, and go to SCAN with the next column. A tick with the row low goes back to HELD.
- Decode when ROWS=4 and COLS=4:
  - Row 0: 1 2 3 A. Row 1: 4 5 6 B. Row 2: 7 8 9 C. Row 3: * 0 # D.
  - Codes: digits map to 0x0–0x9, A–D to 0xA–0xD, * to 0xE, # to 0xF.
- Decode for any other geometry: key_code = key_index[3:0], and the buffer treats only codes 0xE/0xF specially.
- Buffer actions on key_valid:
  - Code 0x0–0x9 with digit_count<DIGITS: shift the buffer left 4 bits, insert the code at [3:0], increment the count.
  - Code 0x0–0x9 with the buffer full: drop the digit; the buffer is unchanged.
  - 0xE (*): clear digits and digit_count to 0.
  - 0xF (#): entry_value←digits and pulse entry_valid, then clear the buffer. Commit with digit_count==0 is legal and yields entry_value=0.
  - 0xA–0xD: event only; no buffer change.

## Timing
- Reset values:
  - col_out = all ones except bit 0 low; state SCAN; all counters 0.
  - key_valid=0, entry_valid=0, key_index=0, key_code=0, digits=0, digit_count=0, entry_value=0.
- Reset mid-debounce or while HELD returns to SCAN with no event issued.
- A press is accepted no earlier than DEBOUNCE ticks after detection, excluding 2 cycles of synchroniser delay.
- key_valid, entry_valid and the buffer update are registered on the same clk edge as the final REL_DB tick.
- digits/digit_count show the new value the cycle key_valid is high.
- Glitches shorter than one tick are not seen. A bounce inside a debounce window restarts the window per the transitions above.
- Simultaneous keys in one column: lowest row wins. Keys in other columns are ignored while not in SCAN.

## Structure
- Package keypad_pkg:
  - Code constants KEY_A..KEY_D, KEY_STAR=4'hE, KEY_HASH=4'hF.
  - FSM state enum {SCAN, PRESS_DB, HELD, REL_DB}.
  - 4x4 decode function.
- Sub-module keypad_digit_buffer (clk, reset, key_valid, key_code, DIGITS) owns digits, digit_count, entry_value and entry_valid.
- The scanner FSM, divider, synchroniser and decode stay in keypad_scanner.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=3, DIGITS=4 with a 4x4 keypad model.
- Press '5' (row1/col1) cleanly for 20 ticks, then release → exactly one key_valid, key_index=5, key_code=0x5, digits=0x0005, digit_count=1.
- Keys 1,2,3,4, then 7, then # → digits=0x1234 (7 dropped), entry_valid pulse with entry_value=0x1234, then digits=0 and digit_count=0.
- Press '8' with 2-tick bounce on press and on release → one key_valid only, key_code=0x8.
- Keys 9, 9, *, # → entry_value=0x0000 on commit. Press 'B' → key_code=0xB with the buffer unchanged.
- Hold '3' and assert reset in HELD, then release → no key_valid; all outputs at reset values; col_out=4'b1110.
- Rows 0 and 2 low together in col 0 → key_code=0x1. Press-and-release of a col2 key while '1' is HELD → ignored.
